sp_ram_ctrl: RTL and testbench
==============================

SP_RAM_CTRL -- requirements
Module: sp_ram_ctrl

Interface
REQ-001 Parameter DATA_WIDTH, default 32: word width in bits; SHALL be a multiple of 8.
REQ-002 Parameter ADDR_WIDTH, default 6: address width; depth SHALL be 2**ADDR_WIDTH words.
REQ-003 Parameter MODE, default 0: write-port read behaviour; 0 = read-first, 1 = write-first, 2 = no-change.
REQ-004 Parameter OUT_REG, default 0: 1 adds an output pipeline register.
REQ-005 clk  in  1  sole clock; all state changes on the rising edge.
REQ-006 reset  in  1  synchronous, active-high reset.
REQ-007 req_valid  in  1  request present.
REQ-008 req_ready  out  1  controller accepts a request this cycle.
REQ-009 req_we  in  1  1 = write, 0 = read.
REQ-010 req_be  in  DATA_WIDTH/8  byte enables for writes; bit i covers byte i.
REQ-011 req_addr  in  ADDR_WIDTH  word address.
REQ-012 req_wdata  in  DATA_WIDTH  write data.
REQ-013 rsp_valid  out  1  one-cycle pulse marking rsp_rdata valid.
REQ-014 rsp_rdata  out  DATA_WIDTH  response data.
REQ-015 clr_start  in  1  request a full-memory clear.
REQ-016 clr_busy  out  1  clear sweep in progress.
REQ-017 clr_done  out  1  one-cycle pulse at end of clear.

Function
REQ-018 Storage SHALL be 2**ADDR_WIDTH words of DATA_WIDTH bits, single port: at most one access (request or clear write) per cycle.
REQ-019 FSM SHALL have two states: IDLE and CLEAR. Reset enters CLEAR, clearing from address 0.
REQ-020 CLEAR: write all-zero to one address per cycle, ascending; after address 2**ADDR_WIDTH-1, go to IDLE. The sweep SHALL take exactly 2**ADDR_WIDTH cycles.
REQ-021 clr_busy SHALL be 1 exactly when the state is CLEAR. clr_done SHALL pulse on the first IDLE cycle after a sweep.
REQ-022 IDLE with clr_start=1: enter CLEAR on the next edge, starting from address 0. clr_start during CLEAR SHALL be ignored; the sweep does not restart.
REQ-023 req_ready SHALL be 1 exactly when the state is IDLE. It SHALL be registered and SHALL NOT depend on clr_start or req_valid.
REQ-024 Request accepted when req_valid & req_ready at a rising edge. A request that coincides with clr_start in IDLE SHALL be accepted and completed before the sweep starts.
REQ-025 Write: update only the bytes with req_be[i]=1. All other bytes SHALL keep their values. req_be=0 leaves memory unchanged but still produces a response.
REQ-026 Each accepted request SHALL produce exactly one response. rsp_valid SHALL pulse 1+OUT_REG cycles after acceptance. There is no response backpressure. Back-to-back requests SHALL give back-to-back responses.
REQ-027 Read response: rsp_rdata = word at req_addr before this edge, including any write accepted on an earlier edge.
REQ-028 Write response, by MODE:
- MODE 0: old word.
- MODE 1: merged new word.
- MODE 2: rsp_rdata holds its previous value.
REQ-029 Responses already in flight when CLEAR starts SHALL still be delivered with their pre-clear data.
REQ-030 rsp_rdata SHALL hold its value between responses.
REQ-031 MODE values other than 0-2 SHALL behave as MODE 0.

Reset
REQ-032 While reset=1, at the following edge:
- req_ready=0, rsp_valid=0, rsp_rdata=0, clr_done=0, clr_busy=0;
- pipeline flushed; clear address = 0.
REQ-033 First edge after reset deasserts: state = CLEAR, clr_busy=1.
REQ-034 Reset during CLEAR or with responses in flight SHALL abort the sweep and discard the pending responses. The sweep SHALL restart from address 0.
REQ-035 Memory contents are undefined until the first sweep completes.

Verification (DATA_WIDTH=32, ADDR_WIDTH=4, OUT_REG=0 unless stated)
REQ-036 Release reset -> clr_busy=1 for 16 cycles, then clr_done pulses once and req_ready=1 the same cycle; a read of any address then returns 0x00000000.
REQ-037 Write 0xAABBCCDD to addr 3 with be=0xF, then write 0x11223344 with be=0x5, then read addr 3 -> rsp_rdata=0xAA22CC44.
REQ-038 Word at addr 5 = 0x12345678, write 0xCAFEF00D with be=0xF, under each mode -> write response:
- MODE 0: 0x12345678;
- MODE 1: 0xCAFEF00D;
- MODE 2: unchanged from the prior response.
REQ-039 OUT_REG=1, reads of addrs 0,1,2 on consecutive cycles -> rsp_valid high for cycles 2,3,4 after the first acceptance, data in order.
REQ-040 IDLE, clr_start=1 with a write of 0xFFFFFFFF to addr 7 in the same cycle -> write response delivered; after clr_done, read addr 7 -> 0x00000000.
REQ-041 Reset asserted at sweep cycle 8 for 1 cycle -> rsp_valid=0; then a full 16-cycle sweep from address 0 and exactly one clr_done.

Source files
------------

// File: rtl/sp_ram_ctrl_if.sv
// Request/response bus between a client and the single-port RAM controller.
// The client drives requests through the master modport; the controller owns ready and the response.
interface sp_ram_ctrl_if #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 6
);
    logic                      req_valid;
    logic                      req_ready;
    logic                      req_we;
    logic [DATA_WIDTH/8-1:0]   req_be;
    logic [ADDR_WIDTH-1:0]     req_addr;
    logic [DATA_WIDTH-1:0]     req_wdata;
    logic                      rsp_valid;
    logic [DATA_WIDTH-1:0]     rsp_rdata;

    modport master (
        output req_valid, req_we, req_be, req_addr, req_wdata,
        input  req_ready, rsp_valid, rsp_rdata
    );

    modport slave (
        input  req_valid, req_we, req_be, req_addr, req_wdata,
        output req_ready, rsp_valid, rsp_rdata
    );
endinterface

// File: rtl/sp_ram_ctrl.sv
// Single-port RAM controller with byte-enabled writes, selectable write-port read behaviour,
// optional output register, and a one-word-per-cycle full-memory clear sweep.
module sp_ram_ctrl #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 6,
    parameter int MODE       = 0,
    parameter int OUT_REG    = 0
) (
    input  logic           clk,
    input  logic           reset,
    sp_ram_ctrl_if.slave   bus,
    input  logic           clr_start,
    output logic           clr_busy,
    output logic           clr_done
);
    localparam int DEPTH    = 2**ADDR_WIDTH;
    localparam int BE_W     = DATA_WIDTH / 8;
    localparam int MODE_EFF = (MODE == 1 || MODE == 2) ? MODE : 0;

    typedef enum logic {
        IDLE  = 1'b0,
        CLEAR = 1'b1
    } state_t;

    state_t                 state;
    state_t                 state_next;
    logic                   hold_q;
    logic [ADDR_WIDTH-1:0]  clr_addr;
    logic [ADDR_WIDTH-1:0]  clr_addr_next;
    logic                   done_next;
    logic                   clr_we;

    logic [DATA_WIDTH-1:0]  mem [DEPTH];
    logic                   accept;
    logic [DATA_WIDTH-1:0]  old_word;
    logic [DATA_WIDTH-1:0]  merged_word;
    logic                   vld_p0;
    logic [DATA_WIDTH-1:0]  rdata_p0;

    function automatic logic [DATA_WIDTH-1:0] merge_bytes(
        input logic [DATA_WIDTH-1:0] old_w,
        input logic [DATA_WIDTH-1:0] new_w,
        input logic [BE_W-1:0]       be
    );
        logic [DATA_WIDTH-1:0] r;
        r = old_w;
        for (int i = 0; i < BE_W; i++) begin
            if (be[i]) begin
                r[8*i +: 8] = new_w[8*i +: 8];
            end
        end
        return r;
    endfunction

    // Write responses in no-change mode re-present the previous response word.
    function automatic logic [DATA_WIDTH-1:0] resp_word(
        input logic                  we,
        input logic [DATA_WIDTH-1:0] old_w,
        input logic [DATA_WIDTH-1:0] new_w,
        input logic [DATA_WIDTH-1:0] prev_w
    );
        logic [DATA_WIDTH-1:0] r;
        r = old_w;
        if (we) begin
            if (MODE_EFF == 1) begin
                r = new_w;
            end else if (MODE_EFF == 2) begin
                r = prev_w;
            end
        end
        return r;
    endfunction

    // hold_q marks the cycle right after reset, when the FSM sits in CLEAR but must not sweep yet.
    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= CLEAR;
            hold_q   <= 1'b1;
            clr_addr <= '0;
            clr_done <= 1'b0;
        end else begin
            state    <= state_next;
            hold_q   <= 1'b0;
            clr_addr <= clr_addr_next;
            clr_done <= done_next;
        end
    end

    always_comb begin
        state_next    = state;
        clr_addr_next = clr_addr;
        done_next     = 1'b0;
        clr_we        = 1'b0;
        case (state)
            IDLE: begin
                if (clr_start) begin
                    state_next    = CLEAR;
                    clr_addr_next = '0;
                end
            end
            CLEAR: begin
                if (!hold_q) begin
                    clr_we        = 1'b1;
                    clr_addr_next = clr_addr + 1'b1;
                    if (&clr_addr) begin
                        state_next = IDLE;
                        done_next  = 1'b1;
                    end
                end
            end
            default: begin
                state_next = CLEAR;
            end
        endcase
    end

    assign bus.req_ready = (state == IDLE);
    assign clr_busy      = (state == CLEAR) && !hold_q;

    assign accept      = bus.req_valid && (state == IDLE) && !reset;
    assign old_word    = mem[bus.req_addr];
    assign merged_word = merge_bytes(old_word, bus.req_wdata, bus.req_be);

    always_ff @(posedge clk) begin
        if (clr_we && !reset) begin
            mem[clr_addr] <= '0;
        end else if (accept && bus.req_we) begin
            for (int i = 0; i < BE_W; i++) begin
                if (bus.req_be[i]) begin
                    mem[bus.req_addr][8*i +: 8] <= bus.req_wdata[8*i +: 8];
                end
            end
        end
    end

    // Stage p0: response captured on the acceptance edge; data word holds between responses.
    always_ff @(posedge clk) begin
        if (reset) begin
            vld_p0   <= 1'b0;
            rdata_p0 <= '0;
        end else begin
            vld_p0 <= accept;
            if (accept) begin
                rdata_p0 <= resp_word(bus.req_we, old_word, merged_word, rdata_p0);
            end
        end
    end

    generate
        if (OUT_REG != 0) begin : g_out_reg
            logic                  vld_p1;
            logic [DATA_WIDTH-1:0] rdata_p1;

            // Stage p1: optional output register.
            always_ff @(posedge clk) begin
                if (reset) begin
                    vld_p1   <= 1'b0;
                    rdata_p1 <= '0;
                end else begin
                    vld_p1 <= vld_p0;
                    if (vld_p0) begin
                        rdata_p1 <= rdata_p0;
                    end
                end
            end

            assign bus.rsp_valid = vld_p1;
            assign bus.rsp_rdata = rdata_p1;
        end else begin : g_direct
            assign bus.rsp_valid = vld_p0;
            assign bus.rsp_rdata = rdata_p0;
        end
    endgenerate
endmodule

// File: tb/tb_sp_ram_ctrl.sv
// Directed bench for sp_ram_ctrl: four instances (read-first, write-first, no-change, registered output)
// share one stimulus stream and are checked against hand-computed values.
module tb_sp_ram_ctrl;
    logic        clk;
    logic        reset;
    logic        req_valid;
    logic        req_we;
    logic [3:0]  req_be;
    logic [3:0]  req_addr;
    logic [31:0] req_wdata;
    logic        clr_start;
    logic        busy0, busy1, busy2, busy3;
    logic        done0, done1, done2, done3;
    int          total;
    int          bad;
    int          busy_cnt;
    int          done_cnt;
    logic        done_ready;

    sp_ram_ctrl_if #(.DATA_WIDTH(32), .ADDR_WIDTH(4)) ifc0 ();
    sp_ram_ctrl_if #(.DATA_WIDTH(32), .ADDR_WIDTH(4)) ifc1 ();
    sp_ram_ctrl_if #(.DATA_WIDTH(32), .ADDR_WIDTH(4)) ifc2 ();
    sp_ram_ctrl_if #(.DATA_WIDTH(32), .ADDR_WIDTH(4)) ifc3 ();

    assign ifc0.req_valid = req_valid;
    assign ifc0.req_we    = req_we;
    assign ifc0.req_be    = req_be;
    assign ifc0.req_addr  = req_addr;
    assign ifc0.req_wdata = req_wdata;
    assign ifc1.req_valid = req_valid;
    assign ifc1.req_we    = req_we;
    assign ifc1.req_be    = req_be;
    assign ifc1.req_addr  = req_addr;
    assign ifc1.req_wdata = req_wdata;
    assign ifc2.req_valid = req_valid;
    assign ifc2.req_we    = req_we;
    assign ifc2.req_be    = req_be;
    assign ifc2.req_addr  = req_addr;
    assign ifc2.req_wdata = req_wdata;
    assign ifc3.req_valid = req_valid;
    assign ifc3.req_we    = req_we;
    assign ifc3.req_be    = req_be;
    assign ifc3.req_addr  = req_addr;
    assign ifc3.req_wdata = req_wdata;

    sp_ram_ctrl #(.DATA_WIDTH(32), .ADDR_WIDTH(4), .MODE(0), .OUT_REG(0)) dut0 (
        .clk(clk), .reset(reset), .bus(ifc0.slave),
        .clr_start(clr_start), .clr_busy(busy0), .clr_done(done0)
    );
    sp_ram_ctrl #(.DATA_WIDTH(32), .ADDR_WIDTH(4), .MODE(1), .OUT_REG(0)) dut1 (
        .clk(clk), .reset(reset), .bus(ifc1.slave),
        .clr_start(clr_start), .clr_busy(busy1), .clr_done(done1)
    );
    sp_ram_ctrl #(.DATA_WIDTH(32), .ADDR_WIDTH(4), .MODE(2), .OUT_REG(0)) dut2 (
        .clk(clk), .reset(reset), .bus(ifc2.slave),
        .clr_start(clr_start), .clr_busy(busy2), .clr_done(done2)
    );
    sp_ram_ctrl #(.DATA_WIDTH(32), .ADDR_WIDTH(4), .MODE(0), .OUT_REG(1)) dut3 (
        .clk(clk), .reset(reset), .bus(ifc3.slave),
        .clr_start(clr_start), .clr_busy(busy3), .clr_done(done3)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic chk1(input string tag, input logic obs, input logic exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic v, input logic we, input logic [3:0] be,
                         input logic [3:0] addr, input logic [31:0] wd);
        req_valid = v;
        req_we    = we;
        req_be    = be;
        req_addr  = addr;
        req_wdata = wd;
        tick();
    endtask

    task automatic issue(input logic we, input logic [3:0] be,
                         input logic [3:0] addr, input logic [31:0] wd);
        drive(1'b1, we, be, addr, wd);
        req_valid = 1'b0;
    endtask

    initial begin
        total     = 0;
        bad       = 0;
        reset     = 1'b1;
        req_valid = 1'b0;
        req_we    = 1'b0;
        req_be    = 4'h0;
        req_addr  = 4'h0;
        req_wdata = 32'h0;
        clr_start = 1'b0;
        tick();
        tick();
        chk1("rst_ready", ifc0.req_ready, 1'b0);
        chk1("rst_rsp_valid", ifc0.rsp_valid, 1'b0);
        chk("rst_rdata", ifc0.rsp_rdata, 32'h0);
        chk1("rst_busy", busy0, 1'b0);
        chk1("rst_done", done0, 1'b0);
        chk1("rst_busy_oreg", busy3, 1'b0);

        // Initial sweep after reset release.
        reset      = 1'b0;
        busy_cnt   = 0;
        done_cnt   = 0;
        done_ready = 1'b0;
        for (int i = 0; i < 40; i++) begin
            tick();
            if (busy0) busy_cnt++;
            if (done0) begin
                done_cnt++;
                done_ready = ifc0.req_ready;
            end
        end
        chk("init_sweep_len", busy_cnt, 32'd16);
        chk("init_done_cnt", done_cnt, 32'd1);
        chk1("init_done_ready", done_ready, 1'b1);

        issue(1'b0, 4'h0, 4'd9, 32'h0);
        chk1("rd9_valid", ifc0.rsp_valid, 1'b1);
        chk("rd9_data", ifc0.rsp_rdata, 32'h0);
        tick();
        chk1("rsp_one_shot", ifc0.rsp_valid, 1'b0);

        // Byte-enable merge.
        issue(1'b1, 4'hF, 4'd3, 32'hAABBCCDD);
        chk("w1_m0", ifc0.rsp_rdata, 32'h00000000);
        chk("w1_m1", ifc1.rsp_rdata, 32'hAABBCCDD);
        chk("w1_m2", ifc2.rsp_rdata, 32'h00000000);
        issue(1'b1, 4'h5, 4'd3, 32'h11223344);
        chk("w2_m0", ifc0.rsp_rdata, 32'hAABBCCDD);
        chk("w2_m1", ifc1.rsp_rdata, 32'hAA22CC44);
        chk("w2_m2", ifc2.rsp_rdata, 32'h00000000);
        chk1("w2_m2_valid", ifc2.rsp_valid, 1'b1);
        issue(1'b0, 4'h0, 4'd3, 32'h0);
        chk("rd3_m0", ifc0.rsp_rdata, 32'hAA22CC44);
        chk("rd3_m2", ifc2.rsp_rdata, 32'hAA22CC44);

        // Write-port read behaviour per mode.
        issue(1'b1, 4'hF, 4'd5, 32'h12345678);
        chk("w5a_m0", ifc0.rsp_rdata, 32'h00000000);
        chk("w5a_m1", ifc1.rsp_rdata, 32'h12345678);
        chk("w5a_m2", ifc2.rsp_rdata, 32'hAA22CC44);
        issue(1'b1, 4'hF, 4'd5, 32'hCAFEF00D);
        chk("w5b_m0", ifc0.rsp_rdata, 32'h12345678);
        chk("w5b_m1", ifc1.rsp_rdata, 32'hCAFEF00D);
        chk("w5b_m2", ifc2.rsp_rdata, 32'hAA22CC44);

        issue(1'b1, 4'h0, 4'd5, 32'hFFFFFFFF);
        chk1("be0_valid", ifc0.rsp_valid, 1'b1);
        chk("be0_data", ifc0.rsp_rdata, 32'hCAFEF00D);
        issue(1'b0, 4'h0, 4'd5, 32'h0);
        chk("be0_unchanged", ifc0.rsp_rdata, 32'hCAFEF00D);

        // Back-to-back traffic, direct and registered outputs.
        drive(1'b1, 1'b1, 4'hF, 4'd0, 32'h000000A0);
        drive(1'b1, 1'b1, 4'hF, 4'd1, 32'h000000A1);
        drive(1'b1, 1'b1, 4'hF, 4'd2, 32'h000000A2);
        req_valid = 1'b0;
        tick();
        tick();
        tick();
        drive(1'b1, 1'b0, 4'h0, 4'd0, 32'h0);
        chk1("b2b_c1_v0", ifc0.rsp_valid, 1'b1);
        chk("b2b_c1_d0", ifc0.rsp_rdata, 32'h000000A0);
        chk1("b2b_c1_v3", ifc3.rsp_valid, 1'b0);
        drive(1'b1, 1'b0, 4'h0, 4'd1, 32'h0);
        chk("b2b_c2_d0", ifc0.rsp_rdata, 32'h000000A1);
        chk1("b2b_c2_v3", ifc3.rsp_valid, 1'b1);
        chk("b2b_c2_d3", ifc3.rsp_rdata, 32'h000000A0);
        drive(1'b1, 1'b0, 4'h0, 4'd2, 32'h0);
        chk("b2b_c3_d0", ifc0.rsp_rdata, 32'h000000A2);
        chk1("b2b_c3_v3", ifc3.rsp_valid, 1'b1);
        chk("b2b_c3_d3", ifc3.rsp_rdata, 32'h000000A1);
        req_valid = 1'b0;
        tick();
        chk1("b2b_c4_v0", ifc0.rsp_valid, 1'b0);
        chk1("b2b_c4_v3", ifc3.rsp_valid, 1'b1);
        chk("b2b_c4_d3", ifc3.rsp_rdata, 32'h000000A2);
        tick();
        chk1("b2b_c5_v3", ifc3.rsp_valid, 1'b0);
        chk("b2b_c5_hold", ifc3.rsp_rdata, 32'h000000A2);

        // Request coinciding with clr_start, then an ignored clr_start mid-sweep.
        issue(1'b1, 4'hF, 4'd7, 32'h00000077);
        clr_start = 1'b1;
        drive(1'b1, 1'b1, 4'hF, 4'd7, 32'hFFFFFFFF);
        req_valid = 1'b0;
        clr_start = 1'b0;
        chk1("clrw_valid", ifc0.rsp_valid, 1'b1);
        chk("clrw_m0", ifc0.rsp_rdata, 32'h00000077);
        chk("clrw_m1", ifc1.rsp_rdata, 32'hFFFFFFFF);
        chk1("clrw_busy", busy0, 1'b1);
        chk1("clrw_ready", ifc0.req_ready, 1'b0);
        busy_cnt = 1;
        done_cnt = 0;
        tick();
        if (busy0) busy_cnt++;
        chk1("inflight_v3", ifc3.rsp_valid, 1'b1);
        chk("inflight_d3", ifc3.rsp_rdata, 32'h00000077);
        clr_start = 1'b1;
        tick();
        if (busy0) busy_cnt++;
        clr_start = 1'b0;
        for (int i = 0; i < 40; i++) begin
            tick();
            if (busy0) busy_cnt++;
            if (done0) done_cnt++;
        end
        chk("clr_sweep_len", busy_cnt, 32'd16);
        chk("clr_done_cnt", done_cnt, 32'd1);
        issue(1'b0, 4'h0, 4'd7, 32'h0);
        chk("clr_rd7", ifc0.rsp_rdata, 32'h00000000);
        issue(1'b0, 4'h0, 4'd1, 32'h0);
        chk("clr_rd1", ifc0.rsp_rdata, 32'h00000000);

        // Reset at sweep cycle 8.
        issue(1'b1, 4'hF, 4'd15, 32'h0000005A);
        issue(1'b0, 4'h0, 4'd15, 32'h0);
        chk("pre_rst_rd15", ifc0.rsp_rdata, 32'h0000005A);
        clr_start = 1'b1;
        tick();
        clr_start = 1'b0;
        busy_cnt = busy0 ? 1 : 0;
        for (int i = 0; i < 7; i++) begin
            tick();
            if (busy0) busy_cnt++;
        end
        chk("abort_at_cycle", busy_cnt, 32'd8);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk1("abort_rsp_valid", ifc0.rsp_valid, 1'b0);
        chk1("abort_rsp_valid3", ifc3.rsp_valid, 1'b0);
        chk("abort_rdata", ifc0.rsp_rdata, 32'h0);
        chk1("abort_busy", busy0, 1'b0);
        chk1("abort_ready", ifc0.req_ready, 1'b0);
        busy_cnt = 0;
        done_cnt = 0;
        for (int i = 0; i < 40; i++) begin
            tick();
            if (busy0) busy_cnt++;
            if (done0) done_cnt++;
        end
        chk("restart_sweep_len", busy_cnt, 32'd16);
        chk("restart_done_cnt", done_cnt, 32'd1);
        issue(1'b0, 4'h0, 4'd15, 32'h0);
        chk("restart_rd15", ifc0.rsp_rdata, 32'h00000000);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
